// File: rtl/multi_issue_pipe_pkg.sv
// -----------------------------------------------------------------------------
// multi_issue_pipe_pkg
// Shared CPU pipeline definitions: register-file geometry, the per-lane
// pipeline entry (everything forwarding needs to see), and width helpers
// used by the pipe ports. Payload width stays a module parameter because
// it differs between the stages that instantiate the pipe.
// -----------------------------------------------------------------------------
package multi_issue_pipe_pkg;

  localparam int RD_W   = 5;   // architectural register index width
  localparam int DATA_W = 32;  // register write-data width

  // One lane of one pipeline stage, minus the opaque payload.
  typedef struct packed {
    logic              valid;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] wdata;
  } pipe_entry_t;

  // Width of a "number of lanes kept" field: must encode 0..lanes.
  function automatic int keep_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  // Width of an occupancy counter: must encode 0..lanes*depth.
  function automatic int occ_w(input int lanes, input int depth);
    return $clog2(lanes * depth + 1);
  endfunction

endpackage

// File: rtl/multi_issue_pipe_fwd_select.sv
// -----------------------------------------------------------------------------
// pipe_fwd_select
// One forwarding lookup port. Scans every in-flight entry and returns the
// write data of the highest-priority valid producer of raddr_i.
//
// Entries arrive pre-ordered by priority: index 0 is the oldest, index N-1
// the youngest, so the last match in the scan wins.
//
// Ports
//   valid_i  [N]        entry valid bits
//   rd_i     [N*5]      entry destination registers
//   wdata_i  [N*32]     entry write data
//   raddr_i  [5]        register being looked up
//   hit_o    [1]        some valid entry writes raddr_i (never for r0)
//   data_o   [32]       data of the youngest such entry, 0 when no hit
// -----------------------------------------------------------------------------
module pipe_fwd_select
  import multi_issue_pipe_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        valid_i,
  input  logic [N*RD_W-1:0]   rd_i,
  input  logic [N*DATA_W-1:0] wdata_i,
  input  logic [RD_W-1:0]     raddr_i,
  output logic                hit_o,
  output logic [DATA_W-1:0]   data_o
);

  // NOTE: every output gets a default before the loop so no path through
  // this block leaves it unassigned, which would infer a latch.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int k = 0; k < N; k++) begin
      // r0 is hard-wired zero and is never a forwarding source.
      if (valid_i[k] && (rd_i[k*RD_W +: RD_W] == raddr_i) && (raddr_i != '0)) begin
        hit_o  = 1'b1;
        data_o = wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/multi_issue_pipe.sv
// -----------------------------------------------------------------------------
// multi_issue_pipe
// LANES-wide, DEPTH-deep register pipeline used for the ID/EX, EX/D$ and D$
// stage registers of the core. Carries {valid, rd, wdata, payload} per lane,
// supports flush, downstream stall, upstream bubble insertion and partial
// squash of the entering group, and offers FWD_PORTS combinational
// forwarding lookups across every stage.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/rd/wdata/payload  entering group, lane 0 oldest
//   stall_up                   producer has nothing this cycle -> bubble
//   stall_down                 consumer stalled -> whole chain holds
//   flush                      clear every stage
//   kill_req, kill_keep        keep only the kill_keep oldest entering lanes
//   fwd_raddr/fwd_hit/fwd_data forwarding lookup ports
//   out_valid/rd/wdata/payload contents of the last stage (0 when invalid)
//   occupancy                  number of valid lanes held in all stages
// -----------------------------------------------------------------------------
module multi_issue_pipe
  import multi_issue_pipe_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int DEPTH     = 2,
  parameter int PAYLOAD_W = 64,
  parameter int FWD_PORTS = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [LANES-1:0]               in_valid,
  input  logic [LANES*RD_W-1:0]          in_rd,
  input  logic [LANES*DATA_W-1:0]        in_wdata,
  input  logic [LANES*PAYLOAD_W-1:0]     in_payload,
  input  logic                           stall_up,
  input  logic                           stall_down,
  input  logic                           flush,
  input  logic                           kill_req,
  input  logic [keep_w(LANES)-1:0]       kill_keep,
  input  logic [FWD_PORTS*RD_W-1:0]      fwd_raddr,
  output logic [FWD_PORTS-1:0]           fwd_hit,
  output logic [FWD_PORTS*DATA_W-1:0]    fwd_data,
  output logic [LANES-1:0]               out_valid,
  output logic [LANES*RD_W-1:0]          out_rd,
  output logic [LANES*DATA_W-1:0]        out_wdata,
  output logic [LANES*PAYLOAD_W-1:0]     out_payload,
  output logic [occ_w(LANES, DEPTH)-1:0] occupancy
);

  localparam int N     = LANES * DEPTH;
  localparam int OCC_W = occ_w(LANES, DEPTH);

  pipe_entry_t          stage_q [DEPTH][LANES];
  pipe_entry_t          stage_d [DEPTH][LANES];
  logic [PAYLOAD_W-1:0] pay_q   [DEPTH][LANES];
  logic [PAYLOAD_W-1:0] pay_d   [DEPTH][LANES];

  // ---------------------------------------------------------------------------
  // Next state. Priority: flush > stall_down > stall_up > kill_req > advance.
  // Stage 0 entries that are not loaded valid are stored as all-zero so that
  // stale rd/wdata never sit behind a cleared valid bit.
  // ---------------------------------------------------------------------------
  always_comb begin : next_state
    stage_d = stage_q;
    pay_d   = pay_q;
    if (flush) begin
      for (int s = 0; s < DEPTH; s++) begin
        for (int l = 0; l < LANES; l++) begin
          stage_d[s][l] = '0;
          pay_d[s][l]   = '0;
        end
      end
    end else if (!stall_down) begin
      for (int s = DEPTH - 1; s > 0; s--) begin
        stage_d[s] = stage_q[s-1];
        pay_d[s]   = pay_q[s-1];
      end
      for (int l = 0; l < LANES; l++) begin
        // A kill keeps lanes 0..kill_keep-1; kill_keep >= LANES keeps all.
        if (!stall_up && in_valid[l] && (!kill_req || (l < int'(kill_keep)))) begin
          stage_d[0][l].valid = 1'b1;
          stage_d[0][l].rd    = in_rd[l*RD_W +: RD_W];
          stage_d[0][l].wdata = in_wdata[l*DATA_W +: DATA_W];
          pay_d[0][l]         = in_payload[l*PAYLOAD_W +: PAYLOAD_W];
        end else begin
          stage_d[0][l] = '0;
          pay_d[0][l]   = '0;
        end
      end
    end
  end

  // NOTE: the data fields are reset along with the valid bits because the
  // outputs must read as zero straight out of reset; this is a small
  // register pipeline, not a RAM, so resetting every bit is cheap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) begin
        for (int l = 0; l < LANES; l++) begin
          stage_q[s][l] <= '0;
          pay_q[s][l]   <= '0;
        end
      end
    end else begin
      stage_q <= stage_d;
      pay_q   <= pay_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs of the last stage, gated so invalid lanes always read as zero
  // (a flush clears only the entries, but gating keeps this robust).
  // ---------------------------------------------------------------------------
  always_comb begin : out_drive
    out_valid   = '0;
    out_rd      = '0;
    out_wdata   = '0;
    out_payload = '0;
    for (int l = 0; l < LANES; l++) begin
      if (stage_q[DEPTH-1][l].valid) begin
        out_valid[l]                        = 1'b1;
        out_rd[l*RD_W +: RD_W]              = stage_q[DEPTH-1][l].rd;
        out_wdata[l*DATA_W +: DATA_W]       = stage_q[DEPTH-1][l].wdata;
        out_payload[l*PAYLOAD_W +: PAYLOAD_W] = pay_q[DEPTH-1][l];
      end
    end
  end

  // Occupancy is a pure function of the registers, so it lags its cause by
  // exactly one edge.
  always_comb begin : occ_count
    occupancy = '0;
    for (int s = 0; s < DEPTH; s++) begin
      for (int l = 0; l < LANES; l++) begin
        occupancy = occupancy + OCC_W'(stage_q[s][l].valid);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding. Entries are flattened oldest-first: the last stage goes to
  // the low indices and stage 0 to the high ones, and within a stage lane
  // order is kept, so a higher index is always the younger producer.
  // ---------------------------------------------------------------------------
  logic [N-1:0]        fv;
  logic [N*RD_W-1:0]   frd;
  logic [N*DATA_W-1:0] fwdata;

  always_comb begin : fwd_flatten
    fv     = '0;
    frd    = '0;
    fwdata = '0;
    for (int s = 0; s < DEPTH; s++) begin
      for (int l = 0; l < LANES; l++) begin
        fv[(DEPTH-1-s)*LANES + l]                         = stage_q[s][l].valid;
        frd[((DEPTH-1-s)*LANES + l)*RD_W +: RD_W]         = stage_q[s][l].rd;
        fwdata[((DEPTH-1-s)*LANES + l)*DATA_W +: DATA_W]  = stage_q[s][l].wdata;
      end
    end
  end

  for (genvar p = 0; p < FWD_PORTS; p++) begin : g_fwd
    pipe_fwd_select #(
      .N(N)
    ) u_fwd_select (
      .valid_i (fv),
      .rd_i    (frd),
      .wdata_i (fwdata),
      .raddr_i (fwd_raddr[p*RD_W +: RD_W]),
      .hit_o   (fwd_hit[p]),
      .data_o  (fwd_data[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: doc/multi_issue_pipe.md
MULTI_ISSUE_PIPE -- requirements
Module: multi_issue_pipe

Interface
REQ-001 Parameter LANES, default 2, number of issue lanes; lane 0 is oldest in program order.
REQ-002 Parameter DEPTH, default 2, number of register stages (DEPTH >= 1).
REQ-003 Parameter PAYLOAD_W, default 64, width of opaque per-lane payload.
REQ-004 Parameter FWD_PORTS, default 2, number of forwarding lookup ports.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 in_valid  in  LANES  lane carries an instruction.
REQ-008 in_rd  in  LANES x 5  destination register; 0 means no register write.
REQ-009 in_wdata  in  LANES x 32  register write data (forwardable).
REQ-010 in_payload  in  LANES x PAYLOAD_W  sideband carried unmodified.
REQ-011 stall_up  in  1  producer stalled; input not presented this cycle.
REQ-012 stall_down  in  1  consumer stalled; whole chain holds.
REQ-013 flush  in  1  discard every stage.
REQ-014 kill_req  in  1  squash younger lanes of the entering group.
REQ-015 kill_keep  in  clog2(LANES+1)  number of oldest lanes kept on kill_req.
REQ-016 fwd_raddr  in  FWD_PORTS x 5  lookup register address.
REQ-017 fwd_hit  out  FWD_PORTS  a valid in-flight producer matches.
REQ-018 fwd_data  out  FWD_PORTS x 32  wdata of youngest matching producer; 0 when no hit.
REQ-019 out_valid / out_rd / out_wdata / out_payload  out  per-lane, widths as inputs  contents of stage DEPTH-1.
REQ-020 occupancy  out  clog2(LANES*DEPTH+1)  count of valid lanes across all stages.

Function
REQ-021 Each stage s holds LANES entries {valid, rd, wdata, payload}; latency input to out_* is exactly DEPTH cycles absent stalls.
REQ-022 Priority per edge: rst_n low > flush > stall_down > stall_up > kill_req > normal advance.
REQ-023 flush: every stage valid bit cleared on next edge, independent of stall_down.
REQ-024 stall_down high (no flush): all stages hold, inputs ignored.
REQ-025 stall_up high, stall_down low: stages 1..DEPTH-1 advance; stage 0 loads a bubble (all valid 0).
REQ-026 kill_req (normal advance): stage 0 loads lanes 0..kill_keep-1 from input, lanes >= kill_keep forced invalid; kill_keep >= LANES keeps all; kill_keep = 0 kills all.
REQ-027 Normal advance: stage 0 <= inputs, stage s <= stage s-1.
REQ-028 Invalid entries SHALL drive rd, wdata, payload as 0 on out_*.
REQ-029 Forwarding is combinational over all stages; match = valid && rd == fwd_raddr && rd != 0.
REQ-030 Forwarding priority: lower stage index (younger) wins; within a stage higher lane wins.
REQ-031 fwd_raddr = 0 SHALL give fwd_hit 0, fwd_data 0.
REQ-032 occupancy reflects registered state only (updates one edge after the causing event).

Reset
REQ-033 rst_n low at an edge: all valid bits, rd, wdata, payload cleared; out_* 0, occupancy 0, fwd_hit 0.
REQ-034 Reset mid-stall or mid-kill overrides those inputs; first post-reset edge behaves per REQ-022.

Structure
REQ-035 Entry struct typedef (valid, rd, wdata) and kill_keep width helper SHALL reside in the shared CPU defines package; payload stays parametric in the module.
REQ-036 Forwarding match/priority logic SHALL be one sub-module, pipe_fwd_select, instantiated FWD_PORTS times.
REQ-037 Block SHALL replace the hand-written ID/EX, EX/D$ and D$ stage registers of the core by instantiation.

Verification
REQ-038 LANES=2, DEPTH=3: inject rd=5/wdata=0xA, rd=6/0xB at cycle 0 -> out_* shows both at cycle 3, occupancy 2 cycles 1-3.
REQ-039 Same group, stall_down held cycles 1-2 -> out_* appears cycle 5, contents unchanged.
REQ-040 kill_req with kill_keep=1 on lanes {rd=3,rd=4} -> only rd=3 exits; fwd_raddr=4 never hits.
REQ-041 Stage 0 lane 0 rd=7/0x11, stage 2 lane 1 rd=7/0x22 -> fwd_data=0x11; same stage lanes 0,1 rd=7 -> lane 1 value.
REQ-042 flush asserted with stall_down high, pipe full -> all valid 0 next edge, occupancy 0.
REQ-043 rst_n low while stall_up and kill_req high -> all outputs 0 next edge; stall_up alone afterward inserts bubbles.
